// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared CtrlPC encoding, fetch states and reset vector
package mips_cpu_pkg;

  // Next-PC selection driven by the control decoder
  typedef enum logic [1:0] {
    CTRL_PC4    = 2'd0,
    CTRL_BRANCH = 2'd1,
    CTRL_JUMP   = 2'd2,
    CTRL_JREG   = 2'd3
  } ctrl_pc_e;

  // Fetch unit sequencing states
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/mips_cpu_pc_next.sv
// rtl/mips_cpu_pc_next.sv - combinational PC+4 and control-transfer target
module mips_cpu_pc_next
  import mips_cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_instr,
  input  logic [1:0]  i_ctrl_pc,
  input  logic [31:0] i_reg_jump_addr,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_target
);

  logic [31:0] w_branch_off;

  assign o_pc_plus4   = i_pc + 32'd4;
  assign w_branch_off = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

  // Select the transfer target; CTRL_PC4 yields PC+4 but is never stored as pending
  always_comb begin
    o_target = o_pc_plus4;
    case (ctrl_pc_e'(i_ctrl_pc))
      CTRL_PC4:    o_target = o_pc_plus4;
      CTRL_BRANCH: o_target = o_pc_plus4 + w_branch_off;
      CTRL_JUMP:   o_target = {o_pc_plus4[31:28], i_instr[25:0], 2'b00};
      CTRL_JREG:   o_target = i_reg_jump_addr;
      default:     o_target = o_pc_plus4;
    endcase
  end

endmodule

// File: rtl/mips_cpu_fetch.sv
// rtl/mips_cpu_fetch.sv - instruction fetch sequencer with delay slot; optional FETCH_ALIGN_CHECK_EN
module mips_cpu_fetch
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        ExecStall,
  input  logic [1:0]  CtrlPC,
  input  logic [31:0] RegJumpAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        active
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_fetch_addr;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pend_target;
  logic         r_pend_valid;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic [31:0]  w_pend_addr;
  logic         w_pend_halt;
  logic         w_accept;
  logic         w_retire;

  mips_cpu_pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_instr         (r_instr[25:0]),
    .i_ctrl_pc       (CtrlPC),
    .i_reg_jump_addr (RegJumpAddr),
    .o_pc_plus4      (w_pc_plus4),
    .o_target        (w_target)
  );

  assign w_accept    = (r_state == ST_FETCH) && !avm_waitrequest;
  assign w_retire    = (r_state == ST_EXEC) && !ExecStall;
  assign w_pend_addr = {r_pend_target[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_pend_halt = (r_pend_target == 32'h0) || (r_pend_target[1:0] != 2'b00);
`else
  assign w_pend_halt = (r_pend_target == 32'h0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_next;
  end

  // Next state: the delay slot retiring decides between fetching the target and halting
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH:  if (!avm_waitrequest) w_state_next = ST_EXEC;
      ST_EXEC:   if (!ExecStall) w_state_next = (r_pend_valid && w_pend_halt) ? ST_HALTED : ST_FETCH;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_FETCH;
    endcase
  end

  // Outputs; the read request is masked while reset is held so it only rises once reset drops
  always_comb begin
    avm_read    = (r_state == ST_FETCH) && !reset;
    avm_address = r_fetch_addr;
    InstrValid  = (r_state == ST_EXEC);
    active      = (r_state != ST_HALTED);
    Instr       = r_instr;
    PC          = r_pc;
    PCPlus8     = r_pc + 32'd8;
  end

  // Datapath: latch fetched word, compute next fetch address, track the pending transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_addr  <= RESET_VECTOR;
      r_pc          <= RESET_VECTOR;
      r_instr       <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= avm_readdata;
        r_pc    <= r_fetch_addr;
      end
      if (w_retire) begin
        if (r_pend_valid) begin
          // Delay slot done: a new transfer request here is ignored
          r_pend_valid <= 1'b0;
          r_fetch_addr <= w_pend_addr;
        end else begin
          r_fetch_addr <= w_pc_plus4;
          if (ctrl_pc_e'(CtrlPC) != CTRL_PC4) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_target;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// tb/tb_mips_cpu_fetch.sv - directed and randomized self-checking bench for mips_cpu_fetch
module tb_mips_cpu_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        ExecStall;
  logic [1:0]  CtrlPC;
  logic [31:0] RegJumpAddr;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        active;

  logic        mem_mode;
  logic [31:0] const_data;
  int          n_pass;
  int          n_total;

  // reference model of the architectural fetch sequence
  logic [31:0] m_next;
  logic [31:0] m_cur;
  logic [31:0] m_pend;
  logic        m_pend_v;
  int          m_phase;

  mips_cpu_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .Instr           (Instr),
    .InstrValid      (InstrValid),
    .ExecStall       (ExecStall),
    .CtrlPC          (CtrlPC),
    .RegJumpAddr     (RegJumpAddr),
    .PC              (PC),
    .PCPlus8         (PCPlus8),
    .active          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign avm_readdata = mem_mode ? mem_word(avm_address) : const_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic rst, input logic wr, input logic st,
                      input logic [1:0] cp, input logic [31:0] rj, input logic [31:0] d);
    @(negedge clk);
    reset = rst; avm_waitrequest = wr; ExecStall = st;
    CtrlPC = cp; RegJumpAddr = rj; const_data = d;
    #1;
  endtask

  task automatic model_reset();
    m_next = 32'hBFC0_0000; m_cur = 32'hBFC0_0000;
    m_pend = '0; m_pend_v = 1'b0; m_phase = 0;
  endtask

  // retire one instruction using the architectural rules
  task automatic model_retire(input logic [1:0] cp, input logic [31:0] rj);
    logic [31:0] pc4, ins, simm, tgt;
    logic        halt;
    pc4 = m_cur + 32'd4;
    ins = mem_word(m_cur);
    if (m_pend_v) begin
      m_pend_v = 1'b0;
      halt = (m_pend == 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      halt = halt || (m_pend % 4 != 0);
`endif
      if (halt) m_phase = 2;
      else begin m_next = m_pend - (m_pend % 4); m_phase = 0; end
    end else begin
      m_next = pc4; m_phase = 0;
      if (cp != 2'd0) begin
        simm = {{16{ins[15]}}, ins[15:0]};
        case (cp)
          2'd1:    tgt = pc4 + simm * 32'd4;
          2'd2:    tgt = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
          default: tgt = rj;
        endcase
        m_pend = tgt; m_pend_v = 1'b1;
      end
    end
  endtask

  initial begin
    logic        wr, st;
    logic [1:0]  cp;
    logic [31:0] rj;
    n_pass = 0; n_total = 0;
    mem_mode = 1'b0; const_data = 32'h2402_0005;
    reset = 1'b1; avm_waitrequest = 1'b0; ExecStall = 1'b0; CtrlPC = 2'd0; RegJumpAddr = '0;

    // reset state
    step(1, 0, 0, 0, 0, 32'h2402_0005);
    step(1, 0, 0, 0, 0, 32'h2402_0005);
    chk("rst_read", avm_read, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_pc", PC, 32'hBFC0_0000);
    chk("rst_instr", Instr, 0);
    chk("rst_active", active, 1);
    chk("rst_addr", avm_address, 32'hBFC0_0000);

    // straight-line fetch, 2-cycle period
    step(0, 0, 0, 0, 0, 32'h2402_0005);
    chk("f0_read", avm_read, 1);
    chk("f0_addr", avm_address, 32'hBFC0_0000);
    chk("f0_valid", InstrValid, 0);
    step(0, 0, 0, 0, 0, 32'h2402_0005);
    chk("e0_valid", InstrValid, 1);
    chk("e0_read", avm_read, 0);
    chk("e0_instr", Instr, 32'h2402_0005);
    chk("e0_pc", PC, 32'hBFC0_0000);
    chk("e0_pc8", PCPlus8, 32'hBFC0_0008);
    step(0, 0, 0, 0, 0, 32'h2402_0005);
    chk("f1_addr", avm_address, 32'hBFC0_0004);
    chk("f1_valid", InstrValid, 0);
    step(0, 0, 0, 0, 0, 32'h2402_0005);
    chk("e1_pc", PC, 32'hBFC0_0004);
    chk("e1_valid", InstrValid, 1);

    // waitrequest held three cycles
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 32'h2402_0005);
      chk("wait_read", avm_read, 1);
      chk("wait_addr", avm_address, 32'hBFC0_0008);
      chk("wait_valid", InstrValid, 0);
    end
    step(0, 0, 0, 0, 0, 32'h8C01_0000);
    chk("wait_acc_addr", avm_address, 32'hBFC0_0008);
    step(0, 0, 0, 0, 0, 32'h8C01_0000);
    chk("wait_instr", Instr, 32'h8C01_0000);
    chk("wait_pc", PC, 32'hBFC0_0008);

    // BEQ with delay slot, then J
    step(0, 0, 0, 0, 0, 32'h0);
    chk("pre_beq_addr", avm_address, 32'hBFC0_000C);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h1000_0003);
    chk("beq_fetch", avm_address, 32'hBFC0_0010);
    step(0, 0, 0, 1, 0, 32'h0);
    chk("beq_pc", PC, 32'hBFC0_0010);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("beq_slot_addr", avm_address, 32'hBFC0_0014);
    step(0, 0, 0, 1, 0, 32'h0);
    chk("beq_slot_pc", PC, 32'hBFC0_0014);
    step(0, 0, 0, 0, 0, 32'h0800_0040);
    chk("beq_target", avm_address, 32'hBFC0_0020);
    step(0, 0, 0, 2, 0, 32'h0);
    chk("j_instr", Instr, 32'h0800_0040);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("j_slot_addr", avm_address, 32'hBFC0_0024);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("j_target", avm_address, 32'hB000_0100);

    // JR to an unaligned target
    step(0, 0, 0, 3, 32'hBFC0_0102, 32'h0);
    chk("jr_pc", PC, 32'hB000_0100);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("jr_slot_addr", avm_address, 32'hB000_0104);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_active", active, 0);
    chk("align_read", avm_read, 0);
`else
    chk("align_read", avm_read, 1);
    chk("align_addr", avm_address, 32'hBFC0_0100);
`endif

    // JR to zero halts after the delay slot
    step(1, 0, 0, 0, 0, 32'h03E0_0008);
    step(0, 0, 0, 0, 0, 32'h03E0_0008);
    chk("halt_f_addr", avm_address, 32'hBFC0_0000);
    step(0, 0, 0, 3, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("halt_slot_addr", avm_address, 32'hBFC0_0004);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("halt_slot_pc", PC, 32'hBFC0_0004);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 32'h0);
      chk("halt_active", active, 0);
      chk("halt_read", avm_read, 0);
      chk("halt_valid", InstrValid, 0);
    end

    // sequential wrap from 0xFFFFFFFC to 0 does not halt
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 3, 32'hFFFF_FFFC, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wrap_fetch", avm_address, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wrap_pc8", PCPlus8, 32'h0000_0004);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wrap_addr", avm_address, 32'h0);
    chk("wrap_read", avm_read, 1);
    chk("wrap_active", active, 1);

    // ExecStall holds Instr/PC; reset mid-stall and mid-fetch
    step(1, 0, 0, 0, 0, 32'h1111_2222);
    step(0, 0, 0, 0, 0, 32'h1111_2222);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0, 0, 32'h3333_4444 + k);
      chk("stall_instr", Instr, 32'h1111_2222);
      chk("stall_pc", PC, 32'hBFC0_0000);
      chk("stall_read", avm_read, 0);
      chk("stall_valid", InstrValid, 1);
    end
    step(1, 0, 1, 0, 0, 32'h0);
    chk("stall_rst_read", avm_read, 0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("stall_rst_addr", avm_address, 32'hBFC0_0000);
    chk("stall_rst_read1", avm_read, 1);
    chk("stall_rst_valid", InstrValid, 0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0);
    chk("wreq_addr", avm_address, 32'hBFC0_0004);
    step(1, 1, 0, 0, 0, 32'h0);
    chk("wreq_rst_read", avm_read, 0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wreq_rst_addr", avm_address, 32'hBFC0_0000);

    // randomized run against the reference model
    mem_mode = 1'b1;
    step(1, 0, 0, 0, 0, 32'h0);
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == 2) begin
        step(0, 0, 0, 0, 0, 32'h0);
        chk("rnd_halt_active", active, 0);
        chk("rnd_halt_read", avm_read, 0);
        step(1, 0, 0, 0, 0, 32'h0);
        model_reset();
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        st = ($urandom_range(0, 3) == 0);
        cp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        rj = $urandom;
        if ($urandom_range(0, 7) != 0) rj[1:0] = 2'b00;
        step(0, wr, st, cp, rj, 32'h0);
        chk("rnd_read", avm_read, (m_phase == 0));
        chk("rnd_valid", InstrValid, (m_phase == 1));
        chk("rnd_active", active, 1);
        if (m_phase == 0) begin
          chk("rnd_addr", avm_address, m_next);
          if (!wr) begin m_cur = m_next; m_phase = 1; end
        end else begin
          chk("rnd_pc", PC, m_cur);
          chk("rnd_instr", Instr, mem_word(m_cur));
          chk("rnd_pc8", PCPlus8, m_cur + 32'd8);
          if (!st) model_retire(cp, rj);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
